qkv_token_scheduler: RTL

Sequencer that drives the shared QKV projection engine across a full sequence of tokens. It accepts SEQ_LEN token embedding vectors over a valid/ready stream and issues one engine run per token, waiting for each run to finish. Each token's Q, K and V vectors are written to the token-indexed Q/K/V buffers through a single write port. It sits between the token embedding source and the QKV engine, and signals the attention-score stage when the whole sequence is projected.

---
 rtl/qkv_token_scheduler.sv | 86 ++++++++
 1 files changed

// File: rtl/qkv_token_scheduler.sv
// qkv_token_scheduler: runs the shared QKV engine once per token and writes each token's Q/K/V to the token-indexed buffers
module qkv_token_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int EMBED_DIM = 64,
  parameter int SEQ_LEN = 8,
  localparam int ADDR_W = SEQ_LEN > 1 ? $clog2(SEQ_LEN) : 1,
  localparam int CNT_W = $clog2(SEQ_LEN + 1),
  localparam int VW = DATA_WIDTH * EMBED_DIM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seq_start,
  input  logic              abort,
  input  logic              tok_valid,
  output logic              tok_ready,
  input  logic [VW-1:0]     tok_data,
  output logic              eng_start,
  output logic [VW-1:0]     eng_vec,
  input  logic              eng_done,
  input  logic [VW-1:0]     eng_q,
  input  logic [VW-1:0]     eng_k,
  input  logic [VW-1:0]     eng_v,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [VW-1:0]     wr_q,
  output logic [VW-1:0]     wr_k,
  output logic [VW-1:0]     wr_v,
  output logic              busy,
  output logic              seq_done,
  output logic [CNT_W-1:0]  tok_count
);
  typedef enum logic [2:0] {IDLE, WAIT_TOK, ISSUE, WAIT_ENG, WRITE, FINISH, DRAIN} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] tok_idx;
  logic last;
  assign last = tok_idx == ADDR_W'(SEQ_LEN - 1);
  // state register; the engine shares rst so reset never needs a drain
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // next state; abort wins over every other input except where the engine is still running
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = seq_start && !abort ? WAIT_TOK : IDLE;
      WAIT_TOK: state_n = abort ? IDLE : tok_valid ? ISSUE : WAIT_TOK;
      ISSUE:    state_n = abort ? DRAIN : WAIT_ENG;
      WAIT_ENG: state_n = eng_done ? (abort ? IDLE : WRITE) : (abort ? DRAIN : WAIT_ENG);
      WRITE:    state_n = abort ? IDLE : last ? FINISH : WAIT_TOK;
      FINISH:   state_n = IDLE;
      DRAIN:    state_n = eng_done ? IDLE : DRAIN;
      default:  state_n = IDLE;
    endcase
  end
  // outputs decoded from the state register only, so no input reaches an output combinationally
  always_comb begin
    tok_ready = state == WAIT_TOK;
    eng_start = state == ISSUE;
    wr_en = state == WRITE;
    seq_done = state == FINISH;
    busy = state != IDLE;
    wr_addr = tok_idx;
  end
  // token index, written count and verbatim data captures
  always_ff @(posedge clk) begin
    if (rst) begin
      tok_idx <= '0;
      tok_count <= '0;
      eng_vec <= '0;
      wr_q <= '0;
      wr_k <= '0;
      wr_v <= '0;
    end else begin
      if (state == IDLE && state_n == WAIT_TOK) begin
        tok_idx <= '0;
        tok_count <= '0;
      end
      if (state == WAIT_TOK && state_n == ISSUE) eng_vec <= tok_data;
      if (state == WAIT_ENG && state_n == WRITE) begin
        wr_q <= eng_q;
        wr_k <= eng_k;
        wr_v <= eng_v;
      end
      if (state == WRITE) tok_count <= tok_count + CNT_W'(1);
      if (state == WRITE && state_n == WAIT_TOK) tok_idx <= tok_idx + ADDR_W'(1);
    end
  end
endmodule
